// File: rtl/instr_buffer.sv
// instr_buffer: compacting fetch-to-decode queue.
// Define IBUF_STATS_EN to add stall/flush event counters.
module instr_buffer #(
    parameter  int INSTR_PER_FETCH = 4,
    parameter  int DECODE_WIDTH    = 4,
    parameter  int DEPTH           = 16,
    parameter  int XLEN            = 32,
    parameter  int ILEN            = 32,
    localparam int CW              = $clog2(DEPTH + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              fe_valid_i,
    output logic                              fe_ready_o,
    input  logic [XLEN-1:0]                   fe_pc_i,
    input  logic [INSTR_PER_FETCH-1:0]        fe_slot_valid_i,
    input  logic [INSTR_PER_FETCH*ILEN-1:0]   fe_instr_i,
    input  logic [INSTR_PER_FETCH*XLEN-1:0]   fe_pred_npc_i,
    output logic [DECODE_WIDTH-1:0]           de_valid_o,
    output logic [DECODE_WIDTH*ILEN-1:0]      de_instr_o,
    output logic [DECODE_WIDTH*XLEN-1:0]      de_pc_o,
    output logic [DECODE_WIDTH*XLEN-1:0]      de_pred_npc_o,
    input  logic                              de_ready_i,
    output logic [CW-1:0]                     count_o
`ifdef IBUF_STATS_EN
    ,
    output logic [31:0]                       stat_stall_o,
    output logic [31:0]                       stat_flush_o
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int IPF = INSTR_PER_FETCH;
    localparam int DW  = DECODE_WIDTH;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pred_npc;
    } ibuf_entry_t;

    ibuf_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_enq;
    logic          w_deq;
    logic [CW-1:0] w_enq_n;
    logic [CW-1:0] w_deq_n;
    logic [AW-1:0] w_wr_idx [IPF];
    ibuf_entry_t   w_slot   [IPF];
    logic [AW-1:0] w_rd_idx [DW];

    assign fe_ready_o = !flush_i && (r_count <= CW'(DEPTH - IPF));
    assign w_enq      = fe_valid_i && fe_ready_o;
    assign w_deq      = de_ready_i && !flush_i;
    assign w_deq_n    = (r_count < CW'(DW)) ? r_count : CW'(DW);
    assign count_o    = r_count;

    // Each valid slot lands at tail plus the number of valid slots below it.
    always_comb begin
        w_enq_n = '0;
        for (int k = 0; k < IPF; k++) begin
            w_wr_idx[k]        = r_tail + w_enq_n[AW-1:0];
            w_slot[k].instr    = fe_instr_i[k*ILEN +: ILEN];
            w_slot[k].pc       = fe_pc_i + XLEN'(4 * k);
            w_slot[k].pred_npc = fe_pred_npc_i[k*XLEN +: XLEN];
            w_enq_n            = w_enq_n + CW'(fe_slot_valid_i[k]);
        end
    end

    always_comb begin
        de_valid_o    = '0;
        de_instr_o    = '0;
        de_pc_o       = '0;
        de_pred_npc_o = '0;
        for (int i = 0; i < DW; i++) begin
            w_rd_idx[i]                   = r_head + AW'(i);
            de_valid_o[i]                 = CW'(i) < w_deq_n;
            de_instr_o[i*ILEN +: ILEN]    = r_mem[w_rd_idx[i]].instr;
            de_pc_o[i*XLEN +: XLEN]       = r_mem[w_rd_idx[i]].pc;
            de_pred_npc_o[i*XLEN +: XLEN] = r_mem[w_rd_idx[i]].pred_npc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            for (int k = 0; k < IPF; k++) begin
                if (fe_slot_valid_i[k]) begin
                    r_mem[w_wr_idx[k]] <= w_slot[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + w_enq_n[AW-1:0];
            end
            if (w_deq) begin
                r_head <= r_head + w_deq_n[AW-1:0];
            end
            r_count <= r_count
                     + (w_enq ? w_enq_n : '0)
                     - (w_deq ? w_deq_n : '0);
        end
    end

`ifdef IBUF_STATS_EN
    logic [31:0] r_stat_stall;
    logic [31:0] r_stat_flush;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stat_stall <= '0;
            r_stat_flush <= '0;
        end else begin
            if (fe_valid_i && !fe_ready_o && r_stat_stall != '1) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
            if (flush_i && r_stat_flush != '1) begin
                r_stat_flush <= r_stat_flush + 32'd1;
            end
        end
    end

    assign stat_stall_o = r_stat_stall;
    assign stat_flush_o = r_stat_flush;
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// tb_instr_buffer: directed and random checks against a queue model.
// Monitor compares every negedge; stimulus queues expected entries.
module tb_instr_buffer;

    localparam int IPF   = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;

    logic              clk_i = 0;
    logic              rst_i;
    logic              flush_i;
    logic              fe_valid_i;
    logic              fe_ready_o;
    logic [31:0]       fe_pc_i;
    logic [IPF-1:0]    fe_slot_valid_i;
    logic [IPF*32-1:0] fe_instr_i;
    logic [IPF*32-1:0] fe_pred_npc_i;
    logic [DW-1:0]     de_valid_o;
    logic [DW*32-1:0]  de_instr_o;
    logic [DW*32-1:0]  de_pc_o;
    logic [DW*32-1:0]  de_pred_npc_o;
    logic              de_ready_i;
    logic [4:0]        count_o;
`ifdef IBUF_STATS_EN
    logic [31:0]       stat_stall_o;
    logic [31:0]       stat_flush_o;
`endif

    instr_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .fe_valid_i(fe_valid_i), .fe_ready_o(fe_ready_o),
        .fe_pc_i(fe_pc_i), .fe_slot_valid_i(fe_slot_valid_i),
        .fe_instr_i(fe_instr_i), .fe_pred_npc_i(fe_pred_npc_i),
        .de_valid_o(de_valid_o), .de_instr_o(de_instr_o),
        .de_pc_o(de_pc_o), .de_pred_npc_o(de_pred_npc_o),
        .de_ready_i(de_ready_i), .count_o(count_o)
`ifdef IBUF_STATS_EN
        , .stat_stall_o(stat_stall_o), .stat_flush_o(stat_flush_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
    } ent_t;

    ent_t q[$];
    ent_t pend[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk_i) begin
        if (!rst_i) begin
            int  n;
            bit  rdy;
            n   = (q.size() < DW) ? q.size() : DW;
            rdy = !flush_i && (DEPTH - q.size() >= IPF);
            chk("count", 32'(count_o), 32'(q.size()));
            chk("fe_ready", 32'(fe_ready_o), 32'(rdy));
            chk("de_valid", 32'(de_valid_o), (32'd1 << n) - 32'd1);
            for (int i = 0; i < n; i++) begin
                chk("lane_instr", de_instr_o[i*32 +: 32], q[i].instr);
                chk("lane_pc", de_pc_o[i*32 +: 32], q[i].pc);
                chk("lane_npc", de_pred_npc_o[i*32 +: 32], q[i].npc);
            end
            if (flush_i) begin
                q.delete();
                pend.delete();
            end else begin
                if (de_ready_i) repeat (n) void'(q.pop_front());
                foreach (pend[j]) q.push_back(pend[j]);
                pend.delete();
            end
        end else begin
            q.delete();
            pend.delete();
        end
    end

    task automatic cyc(bit v, logic [31:0] pc, logic [3:0] m,
                       bit fl, bit dr);
        @(posedge clk_i);
        #1;
        fe_valid_i      = v;
        fe_pc_i         = pc;
        fe_slot_valid_i = m;
        flush_i         = fl;
        de_ready_i      = dr;
        for (int k = 0; k < IPF; k++) begin
            fe_instr_i[k*32 +: 32]    = $urandom;
            fe_pred_npc_i[k*32 +: 32] = $urandom;
        end
        if (v && !fl && (DEPTH - q.size() >= IPF)) begin
            for (int k = 0; k < IPF; k++) begin
                if (m[k]) begin
                    pend.push_back('{fe_instr_i[k*32 +: 32],
                                     pc + 32'(4 * k),
                                     fe_pred_npc_i[k*32 +: 32]});
                end
            end
        end
    endtask

    task automatic idle(bit dr);
        cyc(0, 32'h0, 4'h0, 0, dr);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i      = 1;
        fe_valid_i = 0;
        flush_i    = 0;
        de_ready_i = 0;
        #1;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(de_valid_o), 32'd0);
        q.delete();
        pend.delete();
        @(posedge clk_i);
        #1;
        rst_i = 0;
        #1;
        chk("rst_ready", 32'(fe_ready_o), 32'd1);
    endtask

    logic [31:0] pc_r;
    logic [3:0]  m_r;
    bit          v_r;
`ifdef IBUF_STATS_EN
    logic [31:0] sf0;
`endif

    initial begin
        rst_i           = 1;
        flush_i         = 0;
        fe_valid_i      = 0;
        fe_pc_i         = 0;
        fe_slot_valid_i = 0;
        fe_instr_i      = 0;
        fe_pred_npc_i   = 0;
        de_ready_i      = 0;
        #2;
        chk("init_count", 32'(count_o), 32'd0);
        chk("init_valid", 32'(de_valid_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 0;

        cyc(1, 32'h8000_0000, 4'b1010, 0, 0);
        idle(0);
        @(negedge clk_i);
        #1;
        chk("cmp_valid", 32'(de_valid_o), 32'h3);
        chk("cmp_pc0", de_pc_o[31:0], 32'h8000_0004);
        chk("cmp_pc1", de_pc_o[63:32], 32'h8000_000C);
        chk("cmp_count", 32'(count_o), 32'd2);
        idle(1);
        idle(0);

        for (int g = 0; g < 5; g++) begin
            cyc(1, 32'h1000 + 32'(16 * g), 4'hF, 0, 0);
        end
        idle(0);
        @(negedge clk_i);
        #1;
        chk("fill_count", 32'(count_o), 32'd16);
        chk("fill_ready", 32'(fe_ready_o), 32'd0);
        repeat (5) idle(1);

        cyc(1, 32'h2000, 4'hF, 0, 0);
        cyc(1, 32'h2010, 4'hF, 0, 0);
        cyc(1, 32'h2020, 4'b0001, 0, 0);
        idle(0);
        do_reset();

        for (int g = 0; g < 3; g++) begin
            cyc(1, 32'h3000 + 32'(16 * g), 4'hF, 0, 1);
        end
        cyc(1, 32'h3030, 4'b0011, 0, 1);
        repeat (3) idle(1);
        cyc(1, 32'h4000, 4'hF, 0, 0);
        idle(0);
        idle(1);
        idle(0);
        @(negedge clk_i);
        #1;
        chk("wrap_count", 32'(count_o), 32'd0);

        cyc(1, 32'h5000, 4'hF, 0, 0);
        cyc(1, 32'h6000, 4'b0111, 0, 1);
        idle(0);
        @(negedge clk_i);
        #1;
        chk("sim_count", 32'(count_o), 32'd3);
        chk("sim_pc0", de_pc_o[31:0], 32'h6000);

        cyc(1, 32'h7000, 4'b0111, 0, 0);
`ifdef IBUF_STATS_EN
        #1;
        sf0 = stat_flush_o;
`endif
        cyc(1, 32'h7100, 4'hF, 1, 1);
        #1;
        chk("fl_ready", 32'(fe_ready_o), 32'd0);
        idle(0);
        @(negedge clk_i);
        #1;
        chk("fl_count", 32'(count_o), 32'd0);
`ifdef IBUF_STATS_EN
        chk("fl_stat", stat_flush_o, sf0 + 32'd1);
`endif

        v_r  = 0;
        pc_r = 0;
        m_r  = 0;
        for (int c = 0; c < 3000; c++) begin
            bit fl;
            bit held;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                v_r = 0;
            end
            held = v_r && (DEPTH - q.size() < IPF);
            if (!held) begin
                v_r  = ($urandom_range(0, 3) != 0);
                pc_r = $urandom & 32'hFFFF_FFFC;
                m_r  = 4'($urandom);
            end
            fl = ($urandom_range(0, 39) == 0);
            cyc(v_r, pc_r, m_r, fl, 1'($urandom));
        end
        repeat (6) idle(1);
        @(negedge clk_i);
        #1;
        chk("end_count", 32'(count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
